// File: rtl/mips_mc_pkg.sv
// Shared encodings and enums for the multi-cycle MIPS core.
package mips_mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_SLT  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_LUI  = 3'd4,
        ALU_ZERO = 3'd5
    } alu_op_t;

    // The only legal sll is the all-zero nop; every other shift encoding halts.
    function automatic logic is_legal(input logic [31:0] instr);
        logic ok;
        ok = 1'b0;
        case (instr[31:26])
            OP_RTYPE: ok = (instr == 32'h0) ||
                           (instr[5:0] inside {FN_ADDU, FN_SUBU, FN_SLT, FN_JR});
            OP_J, OP_JAL, OP_BEQ, OP_ORI, OP_LUI, OP_LW, OP_SW: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mips_mc_rf.sv
// 32x32 register file: two asynchronous read ports, one write port, $0 reads as zero.
module mips_mc_rf (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b
);

    logic [31:0] regs [0:31];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == 5'd0) ? 32'h0 : regs[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? 32'h0 : regs[raddr_b];

endmodule

// File: rtl/mips_mc.sv
// Multi-cycle MIPS core on a single req/ack memory port, with a retire/register-write trace.
module mips_mc
    import mips_mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              retire,
    output logic [ADDR_W-1:0] retire_pc,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [31:0]       rf_wdata,
    output logic              halt
);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       ir, a, b, alu_out, mdr;
    logic [31:0]       rf_a, rf_b;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, wb_dest;
    logic [15:0] imm;
    logic [25:0] index;
    logic is_rtype, is_jr, is_j, is_jal, is_beq, is_lw, is_sw, is_ori, is_ctl;

    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign funct = ir[5:0];
    assign imm   = ir[15:0];
    assign index = ir[25:0];

    assign is_rtype = (op == OP_RTYPE);
    assign is_jr    = is_rtype && (funct == FN_JR);
    assign is_j     = (op == OP_J);
    assign is_jal   = (op == OP_JAL);
    assign is_beq   = (op == OP_BEQ);
    assign is_lw    = (op == OP_LW);
    assign is_sw    = (op == OP_SW);
    assign is_ori   = (op == OP_ORI);
    assign is_ctl   = is_beq || is_j || is_jal || is_jr;
    assign wb_dest  = is_rtype ? rd : rt;

    logic [31:0]       imm_ext, alu_b, alu_result, pc4_ext;
    logic [ADDR_W-1:0] pc4, ctl_target;
    alu_op_t           alu_op;

    assign imm_ext = is_ori ? {16'h0, imm} : {{16{imm[15]}}, imm};
    assign alu_b   = is_rtype ? b : imm_ext;
    assign pc4     = pc + ADDR_W'(4);
    assign pc4_ext = 32'(pc4);

    always_comb begin
        alu_op = ALU_ADD;
        if (is_rtype) begin
            case (funct)
                FN_ADDU: alu_op = ALU_ADD;
                FN_SUBU: alu_op = ALU_SUB;
                FN_SLT:  alu_op = ALU_SLT;
                default: alu_op = ALU_ZERO;
            endcase
        end else if (is_ori) begin
            alu_op = ALU_OR;
        end else if (op == OP_LUI) begin
            alu_op = ALU_LUI;
        end
    end

    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_ADD:  alu_result = a + alu_b;
            ALU_SUB:  alu_result = a - alu_b;
            ALU_SLT:  alu_result = {31'h0, $signed(a) < $signed(alu_b)};
            ALU_OR:   alu_result = a | alu_b;
            ALU_LUI:  alu_result = {imm, 16'h0};
            default:  alu_result = '0;
        endcase
    end

    // jr targets drop the low two bits so the bus address stays word-aligned.
    always_comb begin
        ctl_target = pc4;
        if (is_beq) begin
            ctl_target = (a == b) ? ADDR_W'(pc4_ext + {imm_ext[29:0], 2'b00}) : pc4;
        end else if (is_jr) begin
            ctl_target = ADDR_W'(a) & ~ADDR_W'(3);
        end else if (is_j || is_jal) begin
            ctl_target = ADDR_W'({pc4_ext[31:28], index, 2'b00});
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_FETCH;
            pc        <= ADDR_W'(RESET_PC);
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            alu_out   <= '0;
            mdr       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= ADDR_W'(RESET_PC);
            mem_wdata <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (!mem_req) begin
                        mem_req <= 1'b1;
                    end else if (mem_ack) begin
                        ir      <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a     <= rf_a;
                    b     <= rf_b;
                    state <= is_legal(ir) ? S_EXEC : S_HALT;
                end
                S_EXEC: begin
                    alu_out <= alu_result;
                    if (is_ctl) begin
                        pc       <= ctl_target;
                        mem_addr <= ctl_target;
                        mem_req  <= 1'b1;
                        state    <= S_FETCH;
                    end else if (is_lw || is_sw) begin
                        if (alu_result[1:0] != 2'b00) begin
                            state <= S_HALT;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_we   <= is_sw;
                            mem_addr <= ADDR_W'(alu_result);
                            if (is_sw) begin
                                mem_wdata <= b;
                            end
                            state <= S_MEM;
                        end
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        mem_we <= 1'b0;
                        if (is_sw) begin
                            pc       <= pc4;
                            mem_addr <= pc4;
                            state    <= S_FETCH;
                        end else begin
                            mdr     <= mem_rdata;
                            mem_req <= 1'b0;
                            state   <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    pc       <= pc4;
                    mem_addr <= pc4;
                    mem_req  <= 1'b1;
                    state    <= S_FETCH;
                end
                S_HALT: begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
                default: begin
                    state   <= S_HALT;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Trace outputs coincide with the clock edge that performs the architectural write.
    always_comb begin
        retire    = 1'b0;
        retire_pc = '0;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        case (state)
            S_EXEC: begin
                retire = is_ctl;
                if (is_jal) begin
                    rf_we    = 1'b1;
                    rf_waddr = 5'd31;
                    rf_wdata = pc4_ext;
                end
            end
            S_MEM: retire = mem_req && mem_ack && mem_we;
            S_WB: begin
                retire = 1'b1;
                if (wb_dest != 5'd0) begin
                    rf_we    = 1'b1;
                    rf_waddr = wb_dest;
                    rf_wdata = is_lw ? mdr : alu_out;
                end
            end
            default: retire = 1'b0;
        endcase
        if (retire) begin
            retire_pc = pc;
        end
    end

    assign halt = (state == S_HALT);

    mips_mc_rf u_rf (
        .clk     (clk),
        .reset   (reset),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (rs),
        .raddr_b (rt),
        .rdata_a (rf_a),
        .rdata_b (rf_b)
    );

endmodule
